// File: rtl/word_aligner.sv
// word_aligner: frame-alignment controller closing the loop around the barrel
// shifter. Hunts for SYNC_WORD by stepping the rotate distance, verifies the
// frame period, then tracks lock and marks frame starts.
// Optional feature: define WORD_ALIGNER_INVERT_EN to also accept ~SYNC_WORD
// and report the latched polarity on inv.
module word_aligner #(
  parameter int              DATA_W     = 32,
  parameter int              DIST_W     = $clog2(DATA_W),
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(32'h1ACF_FC1D),
  parameter int              FRAME_LEN  = 8,
  parameter int              LOCK_CNT   = 3,
  parameter int              UNLOCK_CNT = 2,
  parameter int              SETTLE_W   = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              sd_valid,
  input  logic [DATA_W-1:0] sd,
  output logic [DIST_W-1:0] dst,
  output logic              locked,
  output logic              frame_start,
  output logic              hunt_wrap,
  output logic              inv
);
  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] VERIFY = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  localparam int PW = $clog2(FRAME_LEN);
  localparam int SW = $clog2(SETTLE_W + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  localparam logic [PW-1:0]     POS_LAST  = PW'(FRAME_LEN - 1);
  localparam logic [SW-1:0]     SET_LAST  = SW'(SETTLE_W - 1);
  localparam logic [MW-1:0]     LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [UW-1:0]     MISS_LAST = UW'(UNLOCK_CNT - 1);
  localparam logic [DIST_W-1:0] DST_LAST  = DIST_W'(DATA_W - 1);

  logic [1:0]    state;
  logic [PW-1:0] pos;       // frame position while verifying/locked
  logic [PW-1:0] tmo;       // non-matching words seen while hunting
  logic [SW-1:0] settle;
  logic [MW-1:0] match_cnt;
  logic [UW-1:0] miss_cnt;

  // hit_any: hunt-time acceptance; hit_pol: compare against the locked polarity
  logic hit_any, hit_pol;

`ifdef WORD_ALIGNER_INVERT_EN
  logic hit_inv;
  assign hit_inv = (sd == ~SYNC_WORD);
  assign hit_any = (sd == SYNC_WORD) || hit_inv;
  assign hit_pol = (sd == (inv ? ~SYNC_WORD : SYNC_WORD));

  // Latch polarity at the hunt match; drop it whenever we fall back to HUNT
  always_ff @(posedge clk) begin
    if (!nrst) inv <= 1'b0;
    else if (sd_valid) begin
      if (state == HUNT && hit_any) inv <= hit_inv;
      else if (state == VERIFY && pos == POS_LAST && !hit_pol) inv <= 1'b0;
      else if (state == LOCKED && pos == POS_LAST && !hit_pol && miss_cnt == MISS_LAST)
        inv <= 1'b0;
    end
  end
`else
  assign hit_any = (sd == SYNC_WORD);
  assign hit_pol = hit_any;
  assign inv     = 1'b0;
`endif

  // Alignment FSM; everything advances only on valid words, pulses self-clear
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= HUNT;
      pos         <= '0;
      tmo         <= '0;
      settle      <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      dst         <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      hunt_wrap   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      hunt_wrap   <= 1'b0;
      if (sd_valid) begin
        case (state)
          HUNT: begin
            if (hit_any) begin
              pos <= '0;
              tmo <= '0;
              if (LOCK_CNT == 1) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                state     <= VERIFY;
                match_cnt <= MW'(1);
              end
            end else if (tmo == POS_LAST) begin
              // a full frame without sync: slip one bit and let the shifter settle
              tmo    <= '0;
              settle <= '0;
              state  <= SETTLE;
              if (dst == DST_LAST) begin
                dst       <= '0;
                hunt_wrap <= 1'b1;
              end else begin
                dst <= dst + 1'b1;
              end
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          SETTLE: begin
            if (settle == SET_LAST) begin
              state  <= HUNT;
              settle <= '0;
              tmo    <= '0;
            end else begin
              settle <= settle + 1'b1;
            end
          end
          VERIFY: begin
            if (pos == POS_LAST) begin
              pos <= '0;
              if (hit_pol) begin
                if (match_cnt == LOCK_LAST) begin
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  match_cnt <= '0;
                  miss_cnt  <= '0;
                end else begin
                  match_cnt <= match_cnt + 1'b1;
                end
              end else begin
                state     <= HUNT;
                match_cnt <= '0;
                tmo       <= '0;
              end
            end else begin
              pos <= pos + 1'b1;
            end
          end
          LOCKED: begin
            // only the expected frame position is compared
            if (pos == POS_LAST) begin
              pos <= '0;
              if (hit_pol) begin
                miss_cnt    <= '0;
                frame_start <= 1'b1;
              end else if (miss_cnt == MISS_LAST) begin
                state    <= HUNT;
                locked   <= 1'b0;
                miss_cnt <= '0;
                tmo      <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              pos <= pos + 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule
